// File: rtl/conv_viterbi_decoder.sv
// conv_viterbi_decoder
//   Hard-decision Viterbi decoder for the rate-1/2 systematic 8-state code
//   x = u, z = u ^ Q2 ^ Q0 (next state {u, Q2, Q1}).
//   The survivors are kept by register exchange. Each frame is decoded on
//   its own: bits come out at a fixed TB_DEPTH latency while the frame is
//   streaming. After the last pair, the remaining bits are flushed from one
//   latched survivor.
//
//   Parameters: TB_DEPTH  survivor length in symbols (4..32)
//               PM_W      path-metric width in bits (4..8)
//   Optional:   define VITERBI_TERM_EN to trace the flush from state 0 when
//               frames are tail-terminated. Otherwise the flush is traced
//               from the best state.
//
//   Ports:
//     clk        rising-edge clock
//     clr        synchronous active-high reset; overrides enable
//     enable     global stall; low freezes all state and forces out_valid=0
//     in_valid   a received pair (xk, zk) is present
//     in_ready   decoder takes a pair this cycle
//     xk, zk     received systematic / parity bit
//     in_last    the pair is the last one of the frame
//     out_valid  out_bit is valid (one-cycle pulse)
//     out_bit    decoded information bit
//     out_last   out_bit is the final bit of the frame
//
//   Handshake: a pair is transferred on a rising edge where in_valid and
//   in_ready are both high. in_ready is low during FLUSH and while enable is
//   low. in_ready does not depend on in_valid. There is no output back-pressure.
module conv_viterbi_decoder #(
    parameter int TB_DEPTH = 16,
    parameter int PM_W     = 6
) (
    input  logic clk,
    input  logic clr,
    input  logic enable,
    input  logic in_valid,
    output logic in_ready,
    input  logic xk,
    input  logic zk,
    input  logic in_last,
    output logic out_valid,
    output logic out_bit,
    output logic out_last
);

    localparam int CW = $clog2(TB_DEPTH);
    localparam logic [PM_W-1:0] PM_MAX = '1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TB_DEPTH - 1);

    typedef enum logic {ACQ = 1'b0, FLUSH = 1'b1} state_t;
    state_t state, state_next;

    logic [PM_W-1:0]     metric     [8];
    logic [TB_DEPTH-1:0] surv       [8];
    logic [PM_W:0]       raw        [8];
    logic [PM_W:0]       diff       [8];
    logic [PM_W-1:0]     metric_new [8];
    logic [TB_DEPTH-1:0] surv_new   [8];
    logic [PM_W:0]       raw_min;
    logic [2:0]          best;
    logic [2:0]          trace;
    logic [CW-1:0]       cnt, cnt_inc, pending;
    logic [TB_DEPTH-1:0] flush_sr;
    logic                valid_r, bit_r, last_r;
    logic                accept, emit_reg, emit_flush, flush_done;

    // Add-compare-select for each next state n. Its predecessors are
    // {n[1], n[0], b}, the input bit is u = n[2], and a tie keeps b = 0.
    for (genvar n = 0; n < 8; n++) begin : g_acs
        localparam logic [2:0] N  = 3'(n);
        localparam logic [2:0] P0 = {N[1], N[0], 1'b0};
        localparam logic [2:0] P1 = {N[1], N[0], 1'b1};
        localparam logic       U  = N[2];
        logic [1:0]    bm0, bm1;
        logic [PM_W:0] c0, c1;
        logic          sel;
        assign bm0 = {1'b0, xk ^ U} + {1'b0, zk ^ U ^ N[1]};
        assign bm1 = {1'b0, xk ^ U} + {1'b0, zk ^ U ^ N[1] ^ 1'b1};
        assign c0  = {1'b0, metric[P0]} + {{(PM_W-1){1'b0}}, bm0};
        assign c1  = {1'b0, metric[P1]} + {{(PM_W-1){1'b0}}, bm1};
        assign sel = (c1 < c0);
        assign raw[n]      = sel ? c1 : c0;
        assign surv_new[n] = sel ? {surv[P1][TB_DEPTH-2:0], U}
                                 : {surv[P0][TB_DEPTH-2:0], U};
    end

    // Best state has the minimum metric. A strict compare keeps the lowest
    // index on a tie. Metrics are normalised to that minimum and clipped.
    always_comb begin
        raw_min = raw[0];
        best    = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (raw[i] < raw_min) begin
                raw_min = raw[i];
                best    = 3'(i);
            end
        end
        for (int i = 0; i < 8; i++) begin
            diff[i]       = raw[i] - raw_min;
            metric_new[i] = (diff[i] > {1'b0, PM_MAX}) ? PM_MAX : diff[i][PM_W-1:0];
        end
    end

`ifdef VITERBI_TERM_EN
    assign trace = 3'd0;
`else
    assign trace = best;
`endif

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (clr)
            state <= ACQ;
        else if (enable)
            state <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            ACQ:     if (accept && in_last) state_next = FLUSH;
            FLUSH:   if (flush_done)        state_next = ACQ;
            default: state_next = ACQ;
        endcase
    end

    // FSM: outputs and per-cycle strobes
    always_comb begin
        in_ready   = (state == ACQ) && enable;
        accept     = in_valid && in_ready;
        emit_reg   = accept && (cnt == CNT_MAX);
        emit_flush = (state == FLUSH) && enable;
        flush_done = emit_flush && (pending == CW'(1));
    end

    // Datapath. The flush reads the latched survivor from index pending-1
    // down to 0. This is oldest first, because the newest decision is in the LSB.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 8; i++) begin
                metric[i] <= PM_MAX;
                surv[i]   <= '0;
            end
            metric[0] <= '0;
            cnt       <= '0;
            pending   <= '0;
            flush_sr  <= '0;
            valid_r   <= 1'b0;
            bit_r     <= 1'b0;
            last_r    <= 1'b0;
        end else if (enable) begin
            valid_r <= emit_reg || emit_flush;
            last_r  <= flush_done;
            if (emit_reg)
                bit_r <= surv_new[best][TB_DEPTH-1];
            else if (emit_flush)
                bit_r <= flush_sr[pending - CW'(1)];
            else
                bit_r <= 1'b0;

            if (accept) begin
                for (int i = 0; i < 8; i++) begin
                    metric[i] <= metric_new[i];
                    surv[i]   <= surv_new[i];
                end
                cnt <= cnt_inc;
                if (in_last) begin
                    pending  <= cnt_inc;
                    flush_sr <= surv_new[trace];
                end
            end

            if (emit_flush)
                pending <= pending - CW'(1);

            // The frame is finished, so restart the trellis from state 0.
            if (flush_done) begin
                for (int i = 0; i < 8; i++) begin
                    metric[i] <= PM_MAX;
                    surv[i]   <= '0;
                end
                metric[0] <= '0;
                cnt       <= '0;
            end
        end
    end

    // A pulse that is registered just before a stall stays hidden until
    // enable returns, so the pulse is delayed and not lost.
    assign out_valid = valid_r && enable;
    assign out_bit   = bit_r;
    assign out_last  = last_r;

endmodule

// File: tb/tb_conv_viterbi_decoder.sv
// Testbench for conv_viterbi_decoder (TB_DEPTH=16, PM_W=6).
// Each expected decoded bit {last, bit} goes into exp_q when its pair is
// driven. The bits are popped and compared when out_valid is seen.
module tb_conv_viterbi_decoder;

    localparam int TB_DEPTH = 16;
    localparam int PM_W     = 6;

    logic clk = 1'b0;
    logic clr, enable, in_valid, xk, zk, in_last;
    logic in_ready, out_valid, out_bit, out_last;

    conv_viterbi_decoder #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) dut (
        .clk(clk), .clr(clr), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready),
        .xk(xk), .zk(zk), .in_last(in_last),
        .out_valid(out_valid), .out_bit(out_bit), .out_last(out_last)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [1:0] exp_q[$];
    logic [1:0] got_q[$];
    logic       capture = 1'b0;
    int total = 0, bad = 0, cyc = 0;
    int out_cnt = 0, acc_cnt = 0;
    int acc16_cyc = -1, first_ov_cyc = -1, last_acc_cyc = -1, last_out_cyc = -1;
    logic accepted;
    logic [2:0] enc_s = 3'd0;

    // Each cycle: observe at the falling edge, then let the rising edge pass.
    task automatic step();
        logic [1:0] e;
        @(negedge clk);
        accepted = in_valid && in_ready && enable;
        if (out_valid === 1'b1) begin
            out_cnt++;
            if (first_ov_cyc < 0) first_ov_cyc = cyc;
            if (out_last === 1'b1) last_out_cyc = cyc;
            if (capture) begin
                got_q.push_back({out_last, out_bit});
            end else begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_extra: got bit=%0b last=%0b, required no output (cyc %0d)",
                             out_bit, out_last, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_last, out_bit} !== e) begin
                        bad++;
                        $display("FAIL sb_bit: got bit=%0b last=%0b, required bit=%0b last=%0b (cyc %0d)",
                                 out_bit, out_last, e[0], e[1], cyc);
                    end
                end
            end
        end
        if (accepted) begin
            acc_cnt++;
            if (acc_cnt == 16) acc16_cyc = cyc;
            last_acc_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic enc(input logic u, output logic x, output logic z);
        x = u;
        z = u ^ enc_s[2] ^ enc_s[0];
        enc_s = {u, enc_s[2], enc_s[1]};
    endtask

    task automatic send_pair(input logic x, input logic z, input logic last);
        bit done = 1'b0;
        in_valid = 1'b1;
        xk = x;
        zk = z;
        in_last = last;
        for (int i = 0; i < 100 && !done; i++) begin
            step();
            if (accepted) done = 1'b1;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no accept in 100 cycles, required accept");
        end
    endtask

    task automatic send_bit(input logic u, input logic last, input logic fx, input logic fz);
        logic x, z;
        enc(u, x, z);
        exp_q.push_back({last, u});
        send_pair(x ^ fx, z ^ fz, last);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
        for (int i = 0; i < 4; i++) step();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d bits still pending, required 0", exp_q.size());
        end
    endtask

    task automatic clear_track();
        out_cnt = 0; acc_cnt = 0;
        acc16_cyc = -1; first_ov_cyc = -1; last_acc_cyc = -1; last_out_cyc = -1;
        enc_s = 3'd0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clr = 1'b1; enable = 1'b1; in_valid = 1'b0; xk = 1'b0; zk = 1'b0; in_last = 1'b0;
        step();
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b, required 0", out_valid); end
        total++; if (out_bit   !== 1'b0) begin bad++; $display("FAIL rst_bit: got %b, required 0", out_bit); end
        total++; if (out_last  !== 1'b0) begin bad++; $display("FAIL rst_last: got %b, required 0", out_last); end
        total++; if (in_ready  !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b, required 1", in_ready); end
        clr = 1'b0;
    endtask

    task automatic test_zero_frame();
        clear_track();
        for (int i = 0; i < 40; i++) send_bit(1'b0, 1'(i == 39), 1'b0, 1'b0);
        drain();
        total++;
        if (first_ov_cyc !== acc16_cyc + 1) begin
            bad++;
            $display("FAIL zero_latency: got first output at cyc %0d, required %0d", first_ov_cyc, acc16_cyc + 1);
        end
        total++;
        if (out_cnt !== 40) begin bad++; $display("FAIL zero_count: got %0d, required 40", out_cnt); end
    endtask

    task automatic test_short_frame();
        clear_track();
        exp_q.push_back(2'b01); exp_q.push_back(2'b00);
        exp_q.push_back(2'b01); exp_q.push_back(2'b11);
        send_pair(1'b1, 1'b1, 1'b0);
        send_pair(1'b0, 1'b1, 1'b0);
        send_pair(1'b1, 1'b1, 1'b0);
        send_pair(1'b1, 1'b1, 1'b1);
        drain();
        total++;
        if (out_cnt !== 4) begin bad++; $display("FAIL short_count: got %0d, required 4", out_cnt); end
        total++;
        if (last_out_cyc - last_acc_cyc !== 5) begin
            bad++;
            $display("FAIL short_timing: got out_last %0d cycles after last accept, required 5",
                     last_out_cyc - last_acc_cyc);
        end
    endtask

    task automatic test_random_error();
        clear_track();
        for (int i = 0; i < 64; i++)
            send_bit(1'($urandom_range(0, 1)), 1'(i == 63), 1'(i == 19), 1'b0);
        drain();
        total++;
        if (out_cnt !== 64) begin bad++; $display("FAIL rand_count: got %0d, required 64", out_cnt); end
    endtask

    task automatic test_clr_mid();
        clear_track();
        for (int i = 0; i < 10; i++)
            send_pair(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        step();
        total++;
        if (out_cnt !== 0) begin bad++; $display("FAIL clr_quiet: got %0d outputs, required 0", out_cnt); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL clr_ready: got %b, required 1", in_ready); end
        clear_track();
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'(i == 4), 1'b0, 1'b0);
        drain();
        total++;
        if (out_cnt !== 5) begin bad++; $display("FAIL clr_next_count: got %0d, required 5", out_cnt); end
    endtask

    task automatic test_clr_flush();
        logic [5:0] src;
        logic x, z;
        clear_track();
        src = 6'($urandom_range(0, 63));
        for (int i = 0; i < 6; i++) begin
            enc(src[i], x, z);
            if (i < 3) exp_q.push_back({1'b0, src[i]});
            send_pair(x, z, 1'(i == 5));
        end
        step(); step(); step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        drain();
        total++;
        if (out_cnt !== 3) begin bad++; $display("FAIL clr_flush_count: got %0d, required 3", out_cnt); end
    endtask

    task automatic test_stall_flush();
        clear_track();
        for (int i = 0; i < 10; i++)
            send_bit(1'($urandom_range(0, 1)), 1'(i == 9), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready: got %b, required 0", in_ready); end
        end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                bad++;
                $display("FAIL stall_quiet: got ready=%b valid=%b, required 0 0", in_ready, out_valid);
            end
        end
        enable = 1'b1;
        drain();
        total++;
        if (last_out_cyc - last_acc_cyc !== 14) begin
            bad++;
            $display("FAIL stall_timing: got out_last %0d cycles after last accept, required 14",
                     last_out_cyc - last_acc_cyc);
        end
    endtask

    task automatic test_back_to_back();
        clear_track();
        for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)), 1'(i == 19), 1'b0, 1'b0);
        enc_s = 3'd0;
        for (int i = 0; i < 16; i++) send_bit(1'($urandom_range(0, 1)), 1'(i == 15), 1'b0, 1'b0);
        drain();
        total++;
        if (out_cnt !== 36) begin bad++; $display("FAIL b2b_count: got %0d, required 36", out_cnt); end
    endtask

`ifdef VITERBI_TERM_EN
    task automatic test_term();
        logic u, x, z;
        clear_track();
        got_q.delete();
        capture = 1'b1;
        for (int i = 0; i < 20; i++) begin
            u = (i < 17) ? 1'($urandom_range(0, 1)) : 1'b0;
            enc(u, x, z);
            send_pair(x ^ 1'(i == 19), z ^ 1'(i == 17), 1'(i == 19));
        end
        for (int i = 0; i < 100 && got_q.size() < 20; i++) step();
        capture = 1'b0;
        total++;
        if (got_q.size() !== 20) begin
            bad++;
            $display("FAIL term_count: got %0d, required 20", got_q.size());
        end else begin
            for (int i = 17; i < 20; i++) begin
                total++;
                if (got_q[i] !== {1'(i == 19), 1'b0}) begin
                    bad++;
                    $display("FAIL term_tail%0d: got bit=%0b last=%0b, required bit=0 last=%0b",
                             i, got_q[i][0], got_q[i][1], i == 19);
                end
            end
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_zero_frame();
        test_short_frame();
        test_random_error();
        test_clr_mid();
        test_clr_flush();
        test_stall_flush();
        test_back_to_back();
`ifdef VITERBI_TERM_EN
        test_term();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_viterbi_decoder.md
CONV_VITERBI_DECODER -- requirements
Module: conv_viterbi_decoder

Interface
REQ-001 SHALL have parameter TB_DEPTH, default 16, meaning survivor length in symbols (range 4..32).
REQ-002 SHALL have parameter PM_W, default 6, meaning path-metric width in bits (range 4..8).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port clr  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port enable  input  1  global stall; low freezes all state.
REQ-006 SHALL have port in_valid  input  1  symbol pair present.
REQ-007 SHALL have port in_ready  output  1  decoder accepts a pair this cycle.
REQ-008 SHALL have port xk  input  1  received systematic bit.
REQ-009 SHALL have port zk  input  1  received parity bit.
REQ-010 SHALL have port in_last  input  1  pair is the last of the frame.
REQ-011 SHALL have port out_valid  output  1  out_bit valid, one-cycle pulse.
REQ-012 SHALL have port out_bit  output  1  decoded information bit.
REQ-013 SHALL have port out_last  output  1  out_bit is the last bit of the frame.

Function
REQ-014 SHALL decode the encoder trellis: state s={Q2,Q1,Q0}; input u gives next state {u,s[2],s[1]}, expected x=u, expected z=u^s[2]^s[0].
REQ-015 SHALL accept a pair only when in_valid && in_ready && enable ("accept").
REQ-016 SHALL compute branch metric = (xk!=x)+(zk!=z), range 0..2.
REQ-017 SHALL, per accept, run add-compare-select for all 8 next states n: predecessors {n[1],n[0],b}, b in {0,1}, u=n[2]; tie selects b=0.
REQ-018 SHALL normalise by subtracting the minimum new metric from all 8, saturating each at 2^PM_W-1.
REQ-019 SHALL keep register-exchange survivors: surv[n] = {surv[pred][TB_DEPTH-2:0], u}, newest bit in LSB.
REQ-020 SHALL define best state as minimum metric, lowest index on tie.
REQ-021 SHALL use FSM states ACQ and FLUSH; in_ready=enable in ACQ, 0 in FLUSH.
REQ-022 SHALL count accepted symbols per frame, saturating at TB_DEPTH-1 (cnt).
REQ-023 SHALL, in ACQ, when an accept occurs with cnt==TB_DEPTH-1 before the accept, pulse out_valid the next cycle with out_bit=surv[best][TB_DEPTH-1] of the updated survivors.
REQ-024 SHALL, on accept with in_last=1, enter FLUSH with pending=cnt after the update (1..TB_DEPTH-1) and latch the trace state.
REQ-025 SHALL in FLUSH emit pending bits oldest first, one per enabled cycle, from the latched survivor, out_last=1 on the final bit.
REQ-026 SHALL, after the final flush bit, return to ACQ with metrics, survivors and cnt re-initialised for the next frame.
REQ-027 SHALL, when a frame of length >= TB_DEPTH ends, emit the regular bit for the in_last symbol (REQ-023) before the flush bits.
REQ-028 SHALL hold all state and drive out_valid=0 while enable=0.
REQ-029 SHALL emit exactly one out_bit per accepted pair per frame.

Reset
REQ-030 SHALL, on clr=1 at a clock edge, set FSM=ACQ, cnt=0, survivors=0, metric[0]=0, metric[1..7]=2^PM_W-1.
REQ-031 SHALL drive out_valid=0, out_bit=0, out_last=0 after reset.
REQ-032 SHALL discard any partial frame or flush when clr asserts mid-operation; clr overrides enable.

Configuration
REQ-033 SHALL, with VITERBI_TERM_EN defined, trace the flush from state 0 (tail-terminated frames); without it, trace the flush from the best state.

Verification
REQ-034 SHALL verify: 40 pairs (0,0), last on 40th -> 40 zero bits, first out_valid one cycle after 16th accept, out_last on 40th bit.
REQ-035 SHALL verify: u=1,0,1,1 sent as (1,1),(0,1),(1,1),(1,1), in_last on 4th -> out 1,0,1,1 during FLUSH, out_last on 4th bit.
REQ-036 SHALL verify: 64 random bits encoded, one bit flipped in xk of pair 20 -> decoded stream matches source exactly.
REQ-037 SHALL verify: clr pulsed after 10 accepts -> no outputs, next frame of 5 zero pairs decodes to 5 zeros.
REQ-038 SHALL verify: enable low 3 cycles mid-flush -> output sequence unchanged, only delayed 3 cycles, in_ready stays 0.
REQ-039 SHALL verify: with VITERBI_TERM_EN, a tail-terminated 20-bit frame with 2 errors in the tail pairs -> tail decoded as 0,0,0.
